// File: rtl/register_32_block_32.sv
// RISC-V integer register file: 32 x 32-bit, two combinational read ports and
// one synchronous write port. x0 is hardwired to zero.
module register_32_block_32 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset_trigger,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic                  write_trigger,
   input  logic [DATA_WIDTH-1:0] write_value,
   output logic [DATA_WIDTH-1:0] rs1_value,
   output logic [DATA_WIDTH-1:0] rs2_value
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (write_trigger && (rd != '0)) begin
         regs_d[rd] = write_value;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge reset_trigger) begin
      if (!reset_trigger) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see only committed state: no bypass from the write port.
   always_comb begin
      rs1_value = '0;
      rs2_value = '0;
      if (reset_trigger && (rs1 != '0)) rs1_value = regs_q[rs1];
      if (reset_trigger && (rs2 != '0)) rs2_value = regs_q[rs2];
   end

endmodule

// File: tb/tb_register_32_block_32.sv
// Self-checking bench for register_32_block_32: directed scenarios plus a
// randomized back-to-back write/read run, checked through an expected queue.
module tb_register_32_block_32;

  logic        clk;
  logic        reset_trigger;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        write_trigger;
  logic [31:0] write_value;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;

  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int errors = 0;
  int checks = 0;

  register_32_block_32 dut (
    .clk           (clk),
    .reset_trigger (reset_trigger),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .write_trigger (write_trigger),
    .write_value   (write_value),
    .rs1_value     (rs1_value),
    .rs2_value     (rs2_value)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // driver: one write cycle; model commits at the rising edge when allowed
  task automatic do_write(input logic [4:0] a, input logic [31:0] v, input logic we);
    @(negedge clk);
    rd = a;
    write_value = v;
    write_trigger = we;
    @(posedge clk);
    if (reset_trigger && we && a != 5'd0) model[a] = v;
    #1;
    write_trigger = 1'b0;
  endtask

  // driver: set read indices and push the expected values
  task automatic drive_read(input logic [4:0] a, input logic [4:0] b);
    rs1 = a;
    rs2 = b;
    exp_q.push_back((a == 5'd0 || !reset_trigger) ? 32'h0 : model[a]);
    exp_q.push_back((b == 5'd0 || !reset_trigger) ? 32'h0 : model[b]);
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    reset_trigger = 1'b0;
    write_trigger = 1'b1;
    rd = 5'd5;
    write_value = 32'hFFFF_FFFF;
    model_clear();
    drive_read(5'd5, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1) begin errors++; $display("FAIL reset_held_rs1 got=%h exp=%h", rs1_value, e1); end
    checks++;
    if (rs2_value !== e2) begin errors++; $display("FAIL reset_held_rs2 got=%h exp=%h", rs2_value, e2); end
    @(negedge clk);
    write_trigger = 1'b0;
    reset_trigger = 1'b1;
    for (int i = 0; i < 32; i += 2) begin
      drive_read(i[4:0], 5'(i + 1));
      #1;
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++;
      if (rs1_value !== e1 || rs2_value !== e2) begin
        errors++;
        $display("FAIL reset_clear idx=%0d got=%h/%h exp=%h/%h", i, rs1_value, rs2_value, e1, e2);
      end
    end
  endtask

  task automatic test_x0();
    logic [31:0] e1, e2;
    do_write(5'd0, 32'hDEAD_BEEF, 1'b1);
    drive_read(5'd0, 5'd0);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL x0_write got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e1, e2;
    do_write(5'd3, 32'h1234_5678, 1'b1);
    drive_read(5'd3, 5'd3);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== 32'h1234_5678 || rs2_value !== e2 || e1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr3_same_idx got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
    do_write(5'd10, 32'hABCD_EF01, 1'b1);
    drive_read(5'd10, 5'd3);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL wr10_rd3 got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
  endtask

  task automatic test_no_write_and_rdw();
    logic [31:0] e1, e2;
    do_write(5'd3, 32'h0, 1'b0);
    drive_read(5'd3, 5'd10);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL we_low got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
    // read-during-write: old value before the edge, new value after
    @(negedge clk);
    rd = 5'd7;
    write_value = 32'h55AA_55AA;
    write_trigger = 1'b1;
    drive_read(5'd7, 5'd7);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL rdw_before got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
    @(posedge clk);
    model[7] = 32'h55AA_55AA;
    #1;
    write_trigger = 1'b0;
    drive_read(5'd7, 5'd3);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL rdw_after got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e1, e2;
    @(negedge clk);
    #2;
    reset_trigger = 1'b0;
    model_clear();
    drive_read(5'd3, 5'd10);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL async_reset got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
    @(negedge clk);
    reset_trigger = 1'b1;
    drive_read(5'd3, 5'd7);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL post_reset_cleared got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
    do_write(5'd4, 32'hCAFE_F00D, 1'b1);
    drive_read(5'd4, 5'd0);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (rs1_value !== e1 || rs2_value !== e2) begin
      errors++;
      $display("FAIL write_resumes got=%h/%h exp=%h/%h", rs1_value, rs2_value, e1, e2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    for (int n = 0; n < 60; n++) begin
      do_write(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0));
      drive_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++;
      if (rs1_value !== e1 || rs2_value !== e2) begin
        errors++;
        $display("FAIL b2b n=%0d rs1=%0d rs2=%0d got=%h/%h exp=%h/%h",
                 n, rs1, rs2, rs1_value, rs2_value, e1, e2);
      end
    end
    for (int i = 0; i < 32; i++) begin
      drive_read(i[4:0], 5'(31 - i));
      #1;
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++;
      if (rs1_value !== e1 || rs2_value !== e2) begin
        errors++;
        $display("FAIL sweep idx=%0d got=%h/%h exp=%h/%h", i, rs1_value, rs2_value, e1, e2);
      end
    end
  endtask

  initial begin
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    write_trigger = 1'b0;
    write_value = '0;
    reset_trigger = 1'b0;
    test_reset();
    test_x0();
    test_write_read();
    test_no_write_and_rdw();
    test_async_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
